// File: rtl/wb_pkg.sv
// Shared writeback-stage types: wb source select, load funct3 codes,
// and the MEM/WB register bundle.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic        rd_wren;
    wb_sel_e     wb_sel;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] ld_rdata;
  } mem_wb_t;

endpackage

// File: rtl/load_extend.sv
// Load data extraction: picks byte/half/word at the address offset,
// extends it, and flags misaligned half/word accesses.
module load_extend
  import wb_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data,
  output logic        o_misalign
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    byte_sh = i_word >> {i_offset, 3'b000};
    half_sh = i_word >> {i_offset[1], 4'b0000};
    b = byte_sh[7:0];
    h = half_sh[15:0];
    o_data = i_word;
    o_misalign = (i_offset != 2'b00);
    unique case (i_funct3)
      F3_LB: begin
        o_data = {{24{b[7]}}, b};
        o_misalign = 1'b0;
      end
      F3_LBU: begin
        o_data = {24'd0, b};
        o_misalign = 1'b0;
      end
      F3_LH: begin
        o_data = {{16{h[15]}}, h};
        o_misalign = i_offset[0];
      end
      F3_LHU: begin
        o_data = {16'd0, h};
        o_misalign = i_offset[0];
      end
      // LW and unused encodings behave as a full-word load
      default: begin
        o_data = i_word;
        o_misalign = (i_offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback mux, regfile write port
// drive and retired-instruction counter.
module mem_wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_mem_valid,
  input  logic [XLEN-1:0]  i_mem_pc,
  input  logic [4:0]       i_mem_rd_addr,
  input  logic             i_mem_rd_wren,
  input  logic [1:0]       i_mem_wb_sel,
  input  logic [2:0]       i_mem_funct3,
  input  logic [XLEN-1:0]  i_mem_alu_result,
  input  logic [XLEN-1:0]  i_mem_ld_rdata,
  output logic [4:0]       o_rd_addr,
  output logic [XLEN-1:0]  o_rd_data,
  output logic             o_rd_wren,
  output logic             o_wb_valid,
  output logic [XLEN-1:0]  o_wb_pc,
  output logic             o_ld_misalign,
  output logic [CNT_W-1:0] o_instret
);

  mem_wb_t          wb_q, wb_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [31:0]      ld_data;
  logic             ld_mis;
  logic             mis;
  logic             retire;

  load_extend u_ld (
    .i_word     (wb_q.ld_rdata),
    .i_offset   (wb_q.alu_result[1:0]),
    .i_funct3   (wb_q.funct3),
    .o_data     (ld_data),
    .o_misalign (ld_mis)
  );

  assign mis = (wb_q.wb_sel == WB_LOAD) & ld_mis;
  // A stalled instruction has not left WB yet, even if flushed
  assign retire = wb_q.valid & ~mis & ~i_stall;

  always_comb begin
    wb_d = wb_q;
    if (i_flush) begin
      wb_d = '0;
    end else if (!i_stall) begin
      wb_d.valid      = i_mem_valid;
      wb_d.pc         = i_mem_pc;
      wb_d.rd_addr    = i_mem_rd_addr;
      wb_d.rd_wren    = i_mem_rd_wren;
      wb_d.wb_sel     = wb_sel_e'(i_mem_wb_sel);
      wb_d.funct3     = i_mem_funct3;
      wb_d.alu_result = i_mem_alu_result;
      wb_d.ld_rdata   = i_mem_ld_rdata;
    end
    instret_d = instret_q + CNT_W'(retire);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wb_q      <= '0;
      instret_q <= '0;
    end else begin
      wb_q      <= wb_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    o_rd_data = wb_q.alu_result;
    unique case (wb_q.wb_sel)
      WB_LOAD: o_rd_data = mis ? 32'd0 : ld_data;
      WB_PC4:  o_rd_data = wb_q.pc + 32'd4;
      default: o_rd_data = wb_q.alu_result;
    endcase
  end

  assign o_rd_addr     = wb_q.rd_addr;
  assign o_rd_wren     = wb_q.valid & wb_q.rd_wren
                       & (wb_q.rd_addr != 5'd0) & ~mis;
  assign o_wb_valid    = wb_q.valid;
  assign o_wb_pc       = wb_q.pc;
  assign o_ld_misalign = mis;
  assign o_instret     = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed vector bench for mem_wb_stage: table of single-cycle
// writeback cases plus stall/flush/reset sequences.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [4:0]  m_rd;
  logic        m_wren;
  logic [1:0]  m_sel;
  logic [2:0]  m_f3;
  logic [31:0] m_alu;
  logic [31:0] m_ld;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_wren;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        ld_mis;
  logic [63:0] instret;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_cnt;
  logic        prev_ok;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .i_stall          (stall),
    .i_flush          (flush),
    .i_mem_valid      (m_valid),
    .i_mem_pc         (m_pc),
    .i_mem_rd_addr    (m_rd),
    .i_mem_rd_wren    (m_wren),
    .i_mem_wb_sel     (m_sel),
    .i_mem_funct3     (m_f3),
    .i_mem_alu_result (m_alu),
    .i_mem_ld_rdata   (m_ld),
    .o_rd_addr        (rd_addr),
    .o_rd_data        (rd_data),
    .o_rd_wren        (rd_wren),
    .o_wb_valid       (wb_valid),
    .o_wb_pc          (wb_pc),
    .o_ld_misalign    (ld_mis),
    .o_instret        (instret)
  );

  typedef struct {
    string       nm;
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] e_data;
    logic        e_wren;
    logic        e_mis;
  } vec_t;

  vec_t tv[14];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] ld);
    m_valid = v;
    m_pc = pc;
    m_rd = rd;
    m_wren = 1'b1;
    m_sel = sel;
    m_f3 = f3;
    m_alu = alu;
    m_ld = ld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 2'b00, 3'b000, 32'd0, 32'd0);
    m_wren = 1'b0;

    tv[0]  = '{"lb0",   1, 32'h10, 5'd3, 2'b01, 3'b000, 32'h1000,
               32'h876543F1, 32'hFFFFFFF1, 1, 0};
    tv[1]  = '{"lbu3",  1, 32'h14, 5'd4, 2'b01, 3'b100, 32'h1003,
               32'h876543F1, 32'h00000087, 1, 0};
    tv[2]  = '{"lhu2",  1, 32'h18, 5'd6, 2'b01, 3'b101, 32'h1002,
               32'h876543F1, 32'h00008765, 1, 0};
    tv[3]  = '{"lh2",   1, 32'h1C, 5'd6, 2'b01, 3'b001, 32'h1002,
               32'h876543F1, 32'hFFFF8765, 1, 0};
    tv[4]  = '{"lwmis", 1, 32'h20, 5'd5, 2'b01, 3'b010, 32'h1002,
               32'h876543F1, 32'h00000000, 0, 1};
    tv[5]  = '{"alux0", 1, 32'h24, 5'd0, 2'b00, 3'b000, 32'h1234,
               32'h0, 32'h00001234, 0, 0};
    tv[6]  = '{"alux7", 1, 32'h28, 5'd7, 2'b00, 3'b000, 32'h1234,
               32'h0, 32'h00001234, 1, 0};
    tv[7]  = '{"jalwr", 1, 32'hFFFFFFFC, 5'd1, 2'b10, 3'b000, 32'h0,
               32'h0, 32'h00000000, 1, 0};
    tv[8]  = '{"jal",   1, 32'h100, 5'd1, 2'b10, 3'b000, 32'h0,
               32'h0, 32'h00000104, 1, 0};
    tv[9]  = '{"lb1",   1, 32'h104, 5'd8, 2'b01, 3'b000, 32'h2001,
               32'h876543F1, 32'h00000043, 1, 0};
    tv[10] = '{"lw0",   1, 32'h108, 5'd9, 2'b01, 3'b010, 32'h2000,
               32'h876543F1, 32'h876543F1, 1, 0};
    tv[11] = '{"rsvd",  1, 32'h10C, 5'd2, 2'b11, 3'b000, 32'hDEAD,
               32'h0, 32'h0000DEAD, 1, 0};
    tv[12] = '{"lhmis", 1, 32'h110, 5'd2, 2'b01, 3'b001, 32'h2001,
               32'h876543F1, 32'h00000000, 0, 1};
    tv[13] = '{"inval", 0, 32'h114, 5'd7, 2'b00, 3'b000, 32'h1234,
               32'h0, 32'h00001234, 0, 0};

    #12;
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_wren", 64'(rd_wren), 64'd0);
    chk("rst_data", 64'(rd_data), 64'd0);
    chk("rst_instret", instret, 64'd0);
    rst_n = 1'b1;
    exp_cnt = 64'd0;
    prev_ok = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(tv[i].v, tv[i].pc, tv[i].rd, tv[i].sel, tv[i].f3,
            tv[i].alu, tv[i].ld);
      step();
      exp_cnt = exp_cnt + 64'(prev_ok);
      prev_ok = tv[i].v & ~tv[i].e_mis;
      chk({tv[i].nm, "_data"}, 64'(rd_data), 64'(tv[i].e_data));
      chk({tv[i].nm, "_wren"}, 64'(rd_wren), 64'(tv[i].e_wren));
      chk({tv[i].nm, "_mis"}, 64'(ld_mis), 64'(tv[i].e_mis));
      chk({tv[i].nm, "_valid"}, 64'(wb_valid), 64'(tv[i].v));
      chk({tv[i].nm, "_pc"}, 64'(wb_pc), 64'(tv[i].pc));
      chk({tv[i].nm, "_rd"}, 64'(rd_addr), 64'(tv[i].rd));
      chk({tv[i].nm, "_instret"}, instret, exp_cnt);
    end

    // stall three cycles, then release with flush
    drive(1'b1, 32'h200, 5'd7, 2'b00, 3'b000, 32'h55, 32'h0);
    step();
    exp_cnt = exp_cnt + 64'(prev_ok);
    chk("st_load_data", 64'(rd_data), 64'h55);
    chk("st_load_instret", instret, exp_cnt);
    stall = 1'b1;
    drive(1'b1, 32'h300, 5'd9, 2'b00, 3'b000, 32'h99, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("st_hold_data", 64'(rd_data), 64'h55);
      chk("st_hold_rd", 64'(rd_addr), 64'd7);
      chk("st_hold_pc", 64'(wb_pc), 64'h200);
      chk("st_hold_wren", 64'(rd_wren), 64'd1);
      chk("st_hold_instret", instret, exp_cnt);
    end
    stall = 1'b0;
    flush = 1'b1;
    step();
    exp_cnt = exp_cnt + 64'd1;
    chk("fl_valid", 64'(wb_valid), 64'd0);
    chk("fl_wren", 64'(rd_wren), 64'd0);
    chk("fl_instret", instret, exp_cnt);
    step();
    chk("fl2_instret", instret, exp_cnt);

    // stall and flush together: bubble, departing op not counted
    flush = 1'b0;
    drive(1'b1, 32'h400, 5'd3, 2'b00, 3'b000, 32'h77, 32'h0);
    step();
    chk("sf_pre_valid", 64'(wb_valid), 64'd1);
    stall = 1'b1;
    flush = 1'b1;
    step();
    chk("sf_valid", 64'(wb_valid), 64'd0);
    chk("sf_instret", instret, exp_cnt);
    stall = 1'b0;
    flush = 1'b0;

    // asynchronous reset with a valid load in WB
    drive(1'b1, 32'h500, 5'd3, 2'b01, 3'b000, 32'h1000, 32'h876543F1);
    step();
    chk("rr_pre_wren", 64'(rd_wren), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_valid", 64'(wb_valid), 64'd0);
    chk("rr_wren", 64'(rd_wren), 64'd0);
    chk("rr_data", 64'(rd_data), 64'd0);
    chk("rr_pc", 64'(wb_pc), 64'd0);
    chk("rr_rd", 64'(rd_addr), 64'd0);
    chk("rr_instret", instret, 64'd0);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 32'h600, 5'd4, 2'b00, 3'b000, 32'h11, 32'h0);
    step();
    chk("post_rst_instret0", instret, 64'd0);
    step();
    chk("post_rst_instret1", instret, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register plus writeback logic for the 5-stage RV32I core. Captures the MEM-stage result bundle on each clock, extracts and sign/zero-extends load data, selects the writeback source, and drives the register file write port (rd address, data, write enable). It also exports the WB result for EX forwarding and maintains a 64-bit retired-instruction counter.

## Interface
- XLEN, 32, datapath width (only 32 supported)
- CNT_W, 64, width of retired-instruction counter
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_stall  in  1  hold WB register contents
- i_flush  in  1  load a bubble into WB
- i_mem_valid  in  1  MEM stage holds a real instruction
- i_mem_pc  in  32  PC of MEM instruction
- i_mem_rd_addr  in  5  destination register
- i_mem_rd_wren  in  1  instruction writes rd
- i_mem_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
- i_mem_funct3  in  3  load size/sign
- i_mem_alu_result  in  32  ALU result / load effective address
- i_mem_ld_rdata  in  32  raw aligned word from data memory (async read)
- o_rd_addr  out  5  to regfile write port
- o_rd_data  out  32  to regfile write port and EX forwarding
- o_rd_wren  out  1  to regfile write port and forwarding unit
- o_wb_valid  out  1  WB holds a real instruction
- o_wb_pc  out  32  PC of WB instruction
- o_ld_misalign  out  1  WB load is misaligned
- o_instret  out  CNT_W  retired-instruction count

## Operation
- Register update priority per rising edge: reset > i_flush (valid=0, rd_wren=0, other fields don't-care, cleared to 0) > i_stall (hold) > capture all i_mem_* fields.
- Load extraction, offset = alu_result[1:0]: LB(000)/LBU(100) select byte at offset, sign/zero-extend; LH(001)/LHU(101) select halfword at offset[1], sign/zero-extend; LW(010) full word; any other funct3 treated as LW.
- Misalignment (wb_sel=01 only): LH/LHU with offset[0]=1, LW with offset≠0. Then o_ld_misalign=1 while in WB, o_rd_wren=0, o_rd_data = 0.
- o_rd_data: ALU → alu_result; load → extended data; PC+4 → pc+4 (mod 2^32, 0xFFFF_FFFC wraps to 0).
- o_rd_wren = valid & rd_wren & (rd_addr≠0) & !misalign.
- o_instret increments by 1 on each edge where valid & !misalign & !i_stall & reset deasserted (instruction leaves WB); wraps at 2^CNT_W−1 → 0. Flush does not suppress counting of the instruction currently leaving WB.

## Timing
- Latency: MEM inputs sampled on edge N appear on all outputs after edge N (combinational from WB register).
- Under stall, outputs are stable; regfile rewrite of the same value is harmless; instret not incremented.
- Stall and flush together: flush wins, bubble inserted, but the departing instruction is not counted (stall held it).
- Reset (any time, asynchronous): all WB fields, all outputs and o_instret = 0; o_rd_wren deasserts immediately.

## Structure
- Package wb_pkg: wb_sel_e enum (WB_ALU, WB_LOAD, WB_PC4, WB_RSVD), funct3 load constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
- Sub-module load_extend (combinational): word, offset, funct3 → extended data, misalign flag.

## Test plan
- Reset mid-run with valid load in WB → all outputs 0, o_instret=0 immediately, before next edge.
- LB, word 0x8765_43F1, addr 0x...0 → rd_data 0xFFFF_FFF1; LBU addr 0x...3 → 0x0000_0087; LHU addr 0x...2 → 0x0000_8765.
- LW addr 0x...2, rd=x5 → o_ld_misalign=1, o_rd_wren=0, o_instret unchanged.
- ALU op rd=x0, result 0x1234 → o_rd_wren=0; same with rd=x7 → wren=1, data 0x1234.
- JAL wb_sel=10, pc 0xFFFF_FFFC → rd_data 0x0000_0000; pc 0x100 → 0x104.
- Valid ALU op, stall 3 cycles then release, then flush → outputs held 3 cycles, instret +1 once, bubble gives o_wb_valid=0.
